// File: rtl/rect_pkg.sv
// ============================================================================
// Module  : rect_pkg
// Brief   : Shared types and helpers for the rectangle-loop pipeline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rect_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_OFFER = 2'd2,
      ST_DONE  = 2'd3
   } rect_state_e;

   // Fields are wide enough for any practical matrix; users slice to RW/CW.
   typedef struct packed {
      logic [7:0] r1;
      logic [7:0] c1;
      logic [7:0] r2;
      logic [7:0] c2;
   } rect_cand_t;

   // Element (r,c) lives at this bit, so (0,0) is the MSB.
   function automatic int bit_idx(input int r, input int c, input int rows, input int cols);
      return rows * cols - 1 - (r * cols + c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rect_corner_check.sv
// ============================================================================
// Module  : rect_corner_check
// Brief   : Extracts the four corners of a candidate and flags a switchable
//           checkerboard (a==d, b==c, a!=b).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_corner_check
   import rect_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input  logic [ROWS*COLS-1:0] mat,
   input  rect_cand_t           cand,
   output logic                 match
);

   localparam int IW = $clog2(ROWS * COLS);

   logic [IW-1:0] w_ia, w_ib, w_ic, w_id;
   logic          w_a, w_b, w_c, w_d;

   always_comb begin
      w_ia  = IW'(bit_idx(int'(cand.r1), int'(cand.c1), ROWS, COLS));
      w_ib  = IW'(bit_idx(int'(cand.r1), int'(cand.c2), ROWS, COLS));
      w_ic  = IW'(bit_idx(int'(cand.r2), int'(cand.c1), ROWS, COLS));
      w_id  = IW'(bit_idx(int'(cand.r2), int'(cand.c2), ROWS, COLS));
      w_a   = mat[w_ia];
      w_b   = mat[w_ib];
      w_c   = mat[w_ic];
      w_d   = mat[w_id];
      match = (w_a == w_d) && (w_b == w_c) && (w_a != w_b);
   end

endmodule

`default_nettype wire

// File: rtl/rect_scan.sv
// ============================================================================
// Module  : rect_scan
// Brief   : Enumerates every rectangle of a binary matrix and offers the
//           switchable ones over valid/ready. Define RECT_SCAN_APPLY_EN to
//           flip accepted corners in the internal matrix.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_scan
   import rect_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [ROWS*COLS-1:0]               m_in,
   output logic                               busy,
   output logic                               rect_valid,
   input  logic                               rect_ready,
   output logic [$clog2(ROWS)-1:0]            r1,
   output logic [$clog2(ROWS)-1:0]            r2,
   output logic [$clog2(COLS)-1:0]            c1,
   output logic [$clog2(COLS)-1:0]            c2,
   output logic                               done,
   output logic [$clog2((ROWS*(ROWS-1)/2)*(COLS*(COLS-1)/2)+1)-1:0] count
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int N     = ROWS * COLS;
   localparam int NCAND = (ROWS * (ROWS - 1) / 2) * (COLS * (COLS - 1) / 2);
   localparam int KW    = $clog2(NCAND + 1);

   localparam logic [1:0] c_IDLE  = ST_IDLE;
   localparam logic [1:0] c_SCAN  = ST_SCAN;
   localparam logic [1:0] c_OFFER = ST_OFFER;
   localparam logic [1:0] c_DONE  = ST_DONE;

   localparam logic [7:0] c_RMAX  = 8'(ROWS - 1);
   localparam logic [7:0] c_CMAX  = 8'(COLS - 1);
   localparam rect_cand_t c_FIRST = {8'd0, 8'd0, 8'd1, 8'd1};
   localparam rect_cand_t c_LAST  = {8'(ROWS - 2), 8'(COLS - 2), 8'(ROWS - 1), 8'(COLS - 1)};
   localparam logic [KW-1:0] c_NCAND = KW'(NCAND);

   logic [1:0]    r_state;
   logic [N-1:0]  r_mat;
   rect_cand_t    r_cand;
   rect_cand_t    w_next;
   logic          w_last;
   logic          w_match;
   logic [KW-1:0] r_count;
   logic [RW-1:0] r_r1, r_r2;
   logic [CW-1:0] r_c1, r_c2;
   logic [N-1:0]  w_mat_hs;

   rect_corner_check #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_check (
      .mat   (r_mat),
      .cand  (r_cand),
      .match (w_match)
   );

   // c2 innermost, then r2, then c1, with r1 outermost.
   always_comb begin
      w_next = r_cand;
      if (r_cand.c2 != c_CMAX) begin
         w_next.c2 = r_cand.c2 + 8'd1;
      end else if (r_cand.r2 != c_RMAX) begin
         w_next.r2 = r_cand.r2 + 8'd1;
         w_next.c2 = r_cand.c1 + 8'd1;
      end else if (r_cand.c1 != c_CMAX - 8'd1) begin
         w_next.c1 = r_cand.c1 + 8'd1;
         w_next.r2 = r_cand.r1 + 8'd1;
         w_next.c2 = r_cand.c1 + 8'd2;
      end else begin
         w_next.r1 = r_cand.r1 + 8'd1;
         w_next.c1 = 8'd0;
         w_next.r2 = r_cand.r1 + 8'd2;
         w_next.c2 = 8'd1;
      end
      w_last = (r_cand == c_LAST);
   end

`ifdef RECT_SCAN_APPLY_EN
   // Accepted corners are flipped so later candidates see the flipped matrix.
   logic [N-1:0] w_mask;
   always_comb begin
      w_mask = '0;
      w_mask[$clog2(N)'(bit_idx(int'(r_cand.r1), int'(r_cand.c1), ROWS, COLS))] = 1'b1;
      w_mask[$clog2(N)'(bit_idx(int'(r_cand.r1), int'(r_cand.c2), ROWS, COLS))] = 1'b1;
      w_mask[$clog2(N)'(bit_idx(int'(r_cand.r2), int'(r_cand.c1), ROWS, COLS))] = 1'b1;
      w_mask[$clog2(N)'(bit_idx(int'(r_cand.r2), int'(r_cand.c2), ROWS, COLS))] = 1'b1;
      w_mat_hs = r_mat ^ w_mask;
   end
`else
   assign w_mat_hs = r_mat;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
         r_mat   <= '0;
         r_cand  <= '0;
         r_count <= '0;
         r_r1    <= '0;
         r_r2    <= '0;
         r_c1    <= '0;
         r_c2    <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_mat   <= m_in;
                  r_count <= '0;
                  r_cand  <= c_FIRST;
                  r_state <= c_SCAN;
               end
            end
            c_SCAN: begin
               if (w_match) begin
                  r_r1    <= r_cand.r1[RW-1:0];
                  r_r2    <= r_cand.r2[RW-1:0];
                  r_c1    <= r_cand.c1[CW-1:0];
                  r_c2    <= r_cand.c2[CW-1:0];
                  r_state <= c_OFFER;
               end else if (w_last) begin
                  r_state <= c_DONE;
               end else begin
                  r_cand  <= w_next;
               end
            end
            c_OFFER: begin
               if (rect_ready) begin
                  r_mat <= w_mat_hs;
                  if (r_count != c_NCAND) begin
                     r_count <= r_count + KW'(1);
                  end
                  if (w_last) begin
                     r_state <= c_DONE;
                  end else begin
                     r_cand  <= w_next;
                     r_state <= c_SCAN;
                  end
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign busy       = (r_state != c_IDLE);
   assign rect_valid = (r_state == c_OFFER);
   assign done       = (r_state == c_DONE);
   assign r1         = r_r1;
   assign r2         = r_r2;
   assign c1         = r_c1;
   assign c2         = r_c2;
   assign count      = r_count;

endmodule

`default_nettype wire
